regfile_rd_sched: RTL and testbench

Controller that sequences and shares the single-read-port, single-write-port 32x32 `regfile_dp` register-file macro. It serialises the two operand reads (rs1, rs2) of each core request through the one asynchronous read port and returns both operands together over a valid/ready handshake. It arbitrates the write port between core writeback (priority) and a debug write port, and enforces x0 semantics. It sits between the core decode/execute logic and the `regfile_dp` instance in `system`.

---
 rtl/regfile_rd_sched_if.sv | 44 ++++
 rtl/regfile_rd_sched.sv | 103 ++++++++++
 tb/tb_regfile_rd_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_rd_sched_if.sv
// rtl/regfile_rd_sched_if.sv - operand read, write arbitration and regfile macro bus for regfile_rd_sched
interface regfile_rd_sched_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          dbg_valid;
    logic          dbg_ready;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_di;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_do;

    modport master (
        output rd_valid, rs1_addr, rs2_addr, rsp_ready,
        output wb_we, wb_addr, wb_data,
        output dbg_valid, dbg_addr, dbg_data,
        output rf_do,
        input  rd_ready, rsp_valid, rs1_data, rs2_data, dbg_ready,
        input  rf_we, rf_waddr, rf_di, rf_raddr
    );

    modport slave (
        input  rd_valid, rs1_addr, rs2_addr, rsp_ready,
        input  wb_we, wb_addr, wb_data,
        input  dbg_valid, dbg_addr, dbg_data,
        input  rf_do,
        output rd_ready, rsp_valid, rs1_data, rs2_data, dbg_ready,
        output rf_we, rf_waddr, rf_di, rf_raddr
    );
endinterface

// File: rtl/regfile_rd_sched.sv
// rtl/regfile_rd_sched.sv - serialises rs1/rs2 reads and arbitrates writes for a 1R1W regfile macro
// Optional write-first capture bypass: REGFILE_RD_BYPASS_EN
module regfile_rd_sched #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             reset_i,
    regfile_rd_sched_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RS1  = 2'd1;
    localparam logic [1:0] RS2  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic [AW-1:0] raddr_q;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rs1_data_q;
    logic [DW-1:0] rs2_data_q;
    logic [DW-1:0] cap;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          we;

    // Core writeback always wins; debug only gets the port on idle writeback cycles.
    always_comb begin
        waddr = bus.wb_we ? bus.wb_addr : bus.dbg_addr;
        wdata = bus.wb_we ? bus.wb_data : bus.dbg_data;
        we    = !reset_i && (bus.wb_we || bus.dbg_valid) && (waddr != '0);
    end

    assign bus.rf_we     = we;
    assign bus.rf_waddr  = waddr;
    assign bus.rf_di     = wdata;
    assign bus.dbg_ready = !reset_i && !bus.wb_we;
    assign bus.rd_ready  = !reset_i && (state == IDLE);
    assign bus.rsp_valid = !reset_i && (state == RESP);
    assign bus.rs1_data  = rs1_data_q;
    assign bus.rs2_data  = rs2_data_q;
    assign bus.rf_raddr  = raddr;

    always_comb begin
        case (state)
            RS1:     raddr = rs1_q;
            RS2:     raddr = rs2_q;
            default: raddr = raddr_q;
        endcase
    end

    always_comb begin
`ifdef REGFILE_RD_BYPASS_EN
        if (we && (waddr == raddr)) begin
            cap = wdata;
        end else begin
            cap = bus.rf_do;
        end
`else
        cap = bus.rf_do;
`endif
        if (raddr == '0) begin
            cap = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state      <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            raddr_q    <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_valid) begin
                        rs1_q <= bus.rs1_addr;
                        rs2_q <= bus.rs2_addr;
                        state <= RS1;
                    end
                end
                RS1: begin
                    rs1_data_q <= cap;
                    raddr_q    <= raddr;
                    state      <= RS2;
                end
                RS2: begin
                    rs2_data_q <= cap;
                    raddr_q    <= raddr;
                    state      <= RESP;
                end
                default: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_rd_sched.sv
// tb/tb_regfile_rd_sched.sv - scoreboard bench for regfile_rd_sched with a behavioural regfile_dp
module tb_regfile_rd_sched;
    logic clk;
    logic reset_i;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] mem    [32];
    logic [31:0] ref_rf [32];
    logic [63:0] sb [$];

    regfile_rd_sched_if #(.AW(5), .DW(32)) bus ();

    regfile_rd_sched #(.AW(5), .DW(32)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural regfile_dp: asynchronous read, synchronous write.
    assign bus.rf_do = mem[bus.rf_raddr];
    always @(posedge clk) begin
        if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_di;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        #1;
        checks++;
        if (bus.rf_we !== (a != 5'd0)) begin
            errors++; $display("FAIL wb_rf_we addr=%0d: got %b expected %b", a, bus.rf_we, (a != 5'd0));
        end
        tick();
        bus.wb_we = 1'b0;
        if (a != 5'd0) ref_rf[a] = d;
    endtask

    task automatic issue_read(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] e1, input logic [31:0] e2);
        bus.rd_valid = 1'b1; bus.rs1_addr = a1; bus.rs2_addr = a2;
        #1;
        checks++;
        if (bus.rd_ready !== 1'b1) begin
            errors++; $display("FAIL rd_ready_idle: got %b expected 1", bus.rd_ready);
        end
        sb.push_back({e1, e2});
        tick();
        bus.rd_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int hold);
        int n;
        logic [63:0] exp_v;
        n = 0;
        bus.rsp_ready = 1'b0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++; $display("FAIL %s_timeout: got rsp_valid=%b expected 1", name, bus.rsp_valid);
        end else if (sb.size() == 0) begin
            errors++; $display("FAIL %s_sb_empty: got response expected none", name);
        end else begin
            exp_v = sb.pop_front();
            checks++;
            if (bus.rs1_data !== exp_v[63:32]) begin
                errors++; $display("FAIL %s_rs1: got %h expected %h", name, bus.rs1_data, exp_v[63:32]);
            end
            checks++;
            if (bus.rs2_data !== exp_v[31:0]) begin
                errors++; $display("FAIL %s_rs2: got %h expected %h", name, bus.rs2_data, exp_v[31:0]);
            end
            for (int i = 0; i < hold; i++) begin
                tick();
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rd_ready !== 1'b0 ||
                    bus.rs1_data !== exp_v[63:32] || bus.rs2_data !== exp_v[31:0]) begin
                    errors++;
                    $display("FAIL %s_hold%0d: got v=%b rdy=%b %h %h expected v=1 rdy=0 %h %h",
                             name, i, bus.rsp_valid, bus.rd_ready, bus.rs1_data, bus.rs2_data,
                             exp_v[63:32], exp_v[31:0]);
                end
            end
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            #1;
            checks++;
            if (bus.rd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL %s_release: got rdy=%b v=%b expected rdy=1 v=0", name, bus.rd_ready, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_data = 32'h5555;
        bus.wb_we = 1'b0;
        tick(); tick();
        #1;
        checks++;
        if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we_dbg: got %b expected 0", bus.rf_we); end
        checks++;
        if (bus.dbg_ready !== 1'b0) begin errors++; $display("FAIL rst_dbg_ready: got %b expected 0", bus.dbg_ready); end
        checks++;
        if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready: got %b expected 0", bus.rd_ready); end
        bus.dbg_valid = 1'b0;
        bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h77;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we_wb: got %b expected 0", bus.rf_we); end
        tick();
        bus.wb_we = 1'b0;
        reset_i = 1'b0;
        tick();
        checks++;
        if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_rd_ready: got %b expected 1", bus.rd_ready); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++;
        if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
            errors++; $display("FAIL post_rst_data: got %h %h expected 0 0", bus.rs1_data, bus.rs2_data);
        end
        checks++;
        if (bus.rf_raddr !== 5'd0) begin errors++; $display("FAIL post_rst_raddr: got %0d expected 0", bus.rf_raddr); end
    endtask

    task automatic test_basic_read();
        wb_write(5'd5, 32'h1234_5678);
        issue_read(5'd5, 5'd0, ref_rf[5], 32'h0);
        #1;
        checks++;
        if (bus.rd_ready !== 1'b0 || bus.rf_raddr !== 5'd5 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL basic_rs1_cycle: got rdy=%b raddr=%0d v=%b expected 0 5 0", bus.rd_ready, bus.rf_raddr, bus.rsp_valid);
        end
        tick();
        checks++;
        if (bus.rf_raddr !== 5'd0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL basic_rs2_cycle: got raddr=%0d v=%b expected 0 0", bus.rf_raddr, bus.rsp_valid);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", bus.rsp_valid); end
        collect("basic", 0);
    endtask

    task automatic test_arbitration();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hAAAA;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd8; bus.dbg_data = 32'hBBBB;
        #1;
        checks++;
        if (bus.dbg_ready !== 1'b0 || bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_di !== 32'hAAAA) begin
            errors++; $display("FAIL arb_core: got dr=%b we=%b a=%0d d=%h expected 0 1 7 0000aaaa", bus.dbg_ready, bus.rf_we, bus.rf_waddr, bus.rf_di);
        end
        tick();
        bus.wb_we = 1'b0;
        ref_rf[7] = 32'hAAAA;
        #1;
        checks++;
        if (bus.dbg_ready !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8 || bus.rf_di !== 32'hBBBB) begin
            errors++; $display("FAIL arb_dbg: got dr=%b we=%b a=%0d d=%h expected 1 1 8 0000bbbb", bus.dbg_ready, bus.rf_we, bus.rf_waddr, bus.rf_di);
        end
        tick();
        bus.dbg_valid = 1'b0;
        ref_rf[8] = 32'hBBBB;
        issue_read(5'd7, 5'd8, ref_rf[7], ref_rf[8]);
        collect("arb", 0);
    endtask

    task automatic test_x0();
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.dbg_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
            errors++; $display("FAIL x0_dbg: got dr=%b we=%b expected 1 0", bus.dbg_ready, bus.rf_we);
        end
        tick();
        bus.dbg_valid = 1'b0;
        issue_read(5'd0, 5'd5, 32'h0, ref_rf[5]);
        collect("x0", 0);
    endtask

    task automatic test_capture_collision();
        logic [31:0] e1;
        wb_write(5'd3, 32'h11);
`ifdef REGFILE_RD_BYPASS_EN
        e1 = 32'h22;
`else
        e1 = 32'h11;
`endif
        issue_read(5'd3, 5'd3, e1, 32'h22);
        bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h22;
        tick();
        bus.wb_we = 1'b0;
        ref_rf[3] = 32'h22;
        collect("collide", 0);
    endtask

    task automatic test_backpressure();
        issue_read(5'd8, 5'd7, ref_rf[8], ref_rf[7]);
        collect("bp", 5);
    endtask

    task automatic test_reset_mid();
        bus.rd_valid = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd7;
        tick();
        bus.rd_valid = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        checks++;
        if (bus.rd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: got rdy=%b v=%b expected 1 0", bus.rd_ready, bus.rsp_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_no_rsp%0d: got %b expected 0", i, bus.rsp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue_read(5'd7, 5'd3, ref_rf[7], ref_rf[3]);
        collect("b2b_a", 0);
        issue_read(5'd5, 5'd8, ref_rf[5], ref_rf[8]);
        collect("b2b_b", 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0;
            ref_rf[i] = 32'h0;
        end
        reset_i = 1'b1;
        bus.rd_valid = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0; bus.rsp_ready = 1'b0;
        bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.dbg_valid = 1'b0; bus.dbg_addr = '0; bus.dbg_data = '0;
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_arbitration();
        test_x0();
        test_capture_collision();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
